// File: rtl/divider_pkg.sv
// Shared constants and state encoding for the 32-bit restoring divider.
package divider_pkg;

  localparam int DIV_WIDTH = 32;
  localparam int DIV_CNT_W = 5;
  localparam logic [DIV_WIDTH-1:0] DIV_BY_ZERO_Q = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/adder_32bit.sv
// 32-bit add/subtract unit. With carry_in_i=1 it computes a_i - b_i and
// carry_out_o reports a borrow (1 when b_i > a_i).
module adder_32bit
  import divider_pkg::*;
(
  input  logic [DIV_WIDTH-1:0] a_i,
  input  logic [DIV_WIDTH-1:0] b_i,
  input  logic                 carry_in_i,
  output logic [DIV_WIDTH-1:0] sum_o,
  output logic                 carry_out_o
);

  logic [DIV_WIDTH-1:0] b_x;
  logic                 msb_cin;
  logic                 carry_raw;

  assign b_x   = b_i ^ {DIV_WIDTH{carry_in_i}};
  assign sum_o = a_i + b_x + {{(DIV_WIDTH-1){1'b0}}, carry_in_i};

  // Recover the carry out of the MSB from the sum bit instead of widening the add.
  assign msb_cin     = sum_o[DIV_WIDTH-1] ^ a_i[DIV_WIDTH-1] ^ b_x[DIV_WIDTH-1];
  assign carry_raw   = (a_i[DIV_WIDTH-1] & b_x[DIV_WIDTH-1]) |
                       ((a_i[DIV_WIDTH-1] ^ b_x[DIV_WIDTH-1]) & msb_cin);
  assign carry_out_o = carry_raw ^ carry_in_i;

endmodule

// File: rtl/divider_32bit.sv
// Multi-cycle restoring divider, one quotient bit per clock (div/divu).
// Signed division and the sign fix-up exist only when DIVIDER_SIGNED_EN is defined.
module divider_32bit
  import divider_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output state_e           dbg_state
);

  // Handshake: start is a single-cycle request taken only in IDLE; busy stays
  // high until done has pulsed, and results hold until the next accepted start.
  state_e                 state_q, state_d;
  logic [DIV_CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]       rem_q, rem_d;
  logic [WIDTH-1:0]       q_q, q_d;
  logic [WIDTH-1:0]       dvsr_q, dvsr_d;
  logic                   dbz_q, dbz_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic [WIDTH-1:0]       quot_q, quot_d;
  logic [WIDTH-1:0]       rmd_q, rmd_d;
  logic                   dbz_out_q, dbz_out_d;

  logic                   accept_start;
  logic [WIDTH-1:0]       shifted;
  logic [WIDTH-1:0]       diff;
  logic                   borrow;
  logic                   take;
  logic [WIDTH-1:0]       step_rem;
  logic [WIDTH-1:0]       step_q;
  logic [WIDTH-1:0]       dividend_mag;
  logic [WIDTH-1:0]       divisor_mag;
  logic [WIDTH-1:0]       final_q;
  logic [WIDTH-1:0]       final_r;

  assign accept_start = (state_q == IDLE) && start;

  assign shifted = {rem_q[WIDTH-2:0], q_q[WIDTH-1]};

  adder_32bit u_trial (
    .a_i         (shifted),
    .b_i         (dvsr_q),
    .carry_in_i  (1'b1),
    .sum_o       (diff),
    .carry_out_o (borrow)
  );

  // A set rem MSB means the shifted value exceeds 32 bits, so it always fits.
  assign take     = rem_q[WIDTH-1] | ~borrow;
  assign step_rem = take ? diff : shifted;
  assign step_q   = {q_q[WIDTH-2:0], take};

`ifdef DIVIDER_SIGNED_EN
  logic             neg_q_q, neg_r_q;
  logic [WIDTH-1:0] neg_a_in, neg_b_in;
  logic [WIDTH-1:0] neg_a, neg_b;
  logic             neg_a_co, neg_b_co;
  logic             unused_carry;

  // The two negators take operands at acceptance and results on the final step.
  assign neg_a_in = (state_q == IDLE) ? dividend : step_q;
  assign neg_b_in = (state_q == IDLE) ? divisor  : step_rem;

  adder_32bit u_neg_a (
    .a_i         ('0),
    .b_i         (neg_a_in),
    .carry_in_i  (1'b1),
    .sum_o       (neg_a),
    .carry_out_o (neg_a_co)
  );

  adder_32bit u_neg_b (
    .a_i         ('0),
    .b_i         (neg_b_in),
    .carry_in_i  (1'b1),
    .sum_o       (neg_b),
    .carry_out_o (neg_b_co)
  );

  assign unused_carry = neg_a_co ^ neg_b_co;

  assign dividend_mag = (is_signed && dividend[WIDTH-1]) ? neg_a : dividend;
  assign divisor_mag  = (is_signed && divisor[WIDTH-1])  ? neg_b : divisor;
  assign final_q      = neg_q_q ? neg_a : step_q;
  assign final_r      = neg_r_q ? neg_b : step_rem;

  always_ff @(posedge clk) begin
    if (reset) begin
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
    end else if (accept_start) begin
      neg_q_q <= is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
      neg_r_q <= is_signed & dividend[WIDTH-1];
    end
  end
`else
  logic unused_is_signed;

  assign unused_is_signed = is_signed;
  assign dividend_mag     = dividend;
  assign divisor_mag      = divisor;
  assign final_q          = step_q;
  assign final_r          = step_rem;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    q_d       = q_q;
    dvsr_d    = dvsr_q;
    dbz_d     = dbz_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    quot_d    = quot_q;
    rmd_d     = rmd_q;
    dbz_out_d = dbz_out_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = RUN;
          cnt_d     = {DIV_CNT_W{1'b1}};
          rem_d     = '0;
          q_d       = dividend_mag;
          dvsr_d    = divisor_mag;
          dbz_d     = (divisor == '0);
          busy_d    = 1'b1;
          quot_d    = '0;
          rmd_d     = '0;
          dbz_out_d = 1'b0;
        end
      end
      RUN: begin
        rem_d = step_rem;
        q_d   = step_q;
        cnt_d = cnt_q - DIV_CNT_W'(1);
        if (cnt_q == '0) begin
          // Results and done are registered together so they appear in DONE.
          state_d   = DONE;
          done_d    = 1'b1;
          quot_d    = dbz_q ? DIV_BY_ZERO_Q : final_q;
          rmd_d     = final_r;
          dbz_out_d = dbz_q;
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      q_q       <= '0;
      dvsr_q    <= '0;
      dbz_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      quot_q    <= '0;
      rmd_q     <= '0;
      dbz_out_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      q_q       <= q_d;
      dvsr_q    <= dvsr_d;
      dbz_q     <= dbz_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      quot_q    <= quot_d;
      rmd_q     <= rmd_d;
      dbz_out_q <= dbz_out_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quot_q;
  assign remainder   = rmd_q;
  assign div_by_zero = dbz_out_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_divider_32bit.sv
// Self-checking bench for divider_32bit; expectations follow DIVIDER_SIGNED_EN.
module tb_divider_32bit;
  import divider_pkg::*;

  localparam int W = 65;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        is_signed;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;
  state_e      dbg_state;

  int checks = 0;
  int passed = 0;
  logic [W-1:0] exp_q[$];

  divider_32bit dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .is_signed   (is_signed),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .dbg_state   (dbg_state)
  );

  always #5 clk = ~clk;

  // Reference result packed as {div_by_zero, quotient, remainder}.
  function automatic logic [W-1:0] model(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa, sb, sq, sr;
    if (b == 32'd0) return {1'b1, 32'hFFFF_FFFF, a};
`ifdef DIVIDER_SIGNED_EN
    if (sgn) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {1'b0, 32'h8000_0000, 32'd0};
      sa = a;
      sb = b;
      sq = sa / sb;
      sr = sa % sb;
      return {1'b0, sq, sr};
    end
`else
    sa = 32'sd0; sb = 32'sd0; sq = 32'sd0; sr = 32'sd0;
    if (sgn) sa = 32'sd0;
`endif
    return {1'b0, a / b, a % b};
  endfunction

  // Called at a negedge: drives start for one cycle, optionally records the expectation.
  task automatic drive_start(input logic sgn, input logic [31:0] a, input logic [31:0] b, input bit push);
    start = 1'b1;
    is_signed = sgn;
    dividend = a;
    divisor = b;
    if (push) exp_q.push_back(model(sgn, a, b));
    @(negedge clk);
    start = 1'b0;
  endtask

  // Counts cycles after acceptance until done, bounded at 60.
  task automatic wait_done(inout int cyc);
    while (done !== 1'b1 && cyc < 60) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    start = 1'b0;
    is_signed = 1'b0;
    dividend = '0;
    divisor = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, quotient, remainder, div_by_zero} !== 67'd0 || dbg_state !== IDLE)
      $display("FAIL reset_state: busy=%b done=%b q=%h r=%h dbz=%b st=%0d, required all 0 / IDLE",
               busy, done, quotient, remainder, div_by_zero, dbg_state);
    else passed++;
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_divu;
    logic [31:0] va[6] = '{32'd100, 32'hFFFF_FFFF, 32'd5, 32'd0, 32'hDEAD_BEEF, 32'd7};
    logic [31:0] vb[6] = '{32'd7, 32'd1, 32'hFFFF_FFFF, 32'd3, 32'h10, 32'd7};
    logic [W-1:0] e;
    int cyc;
    for (int i = 0; i < 6; i++) begin
      drive_start(1'b0, va[i], vb[i], 1);
      checks++;
      if (busy !== 1'b1) $display("FAIL divu_busy[%0d]: busy=%b required 1", i, busy);
      else passed++;
      cyc = 1;
      wait_done(cyc);
      checks++;
      if (cyc !== 33) $display("FAIL divu_latency[%0d]: %0d cycles, required 33", i, cyc);
      else passed++;
      e = exp_q.pop_front();
      checks++;
      if ({div_by_zero, quotient, remainder} !== e)
        $display("FAIL divu_result[%0d]: q=%h r=%h dbz=%b, required q=%h r=%h dbz=%b",
                 i, quotient, remainder, div_by_zero, e[63:32], e[31:0], e[64]);
      else passed++;
      if (i == 0) begin
        checks++;
        if (quotient !== 32'd14 || remainder !== 32'd2)
          $display("FAIL divu_100_7: q=%0d r=%0d, required q=14 r=2", quotient, remainder);
        else passed++;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_signed;
    logic [31:0] va[4] = '{32'hFFFF_FF9C, 32'd100, 32'hFFFF_FF9C, 32'h8000_0000};
    logic [31:0] vb[4] = '{32'd7, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'hFFFF_FFFF};
    logic [W-1:0] e;
    int cyc;
    for (int i = 0; i < 4; i++) begin
      drive_start(1'b1, va[i], vb[i], 1);
      cyc = 1;
      wait_done(cyc);
      checks++;
      if (cyc !== 33) $display("FAIL div_latency[%0d]: %0d cycles, required 33", i, cyc);
      else passed++;
      e = exp_q.pop_front();
      checks++;
      if ({div_by_zero, quotient, remainder} !== e)
        $display("FAIL div_result[%0d]: q=%h r=%h dbz=%b, required q=%h r=%h dbz=%b",
                 i, quotient, remainder, div_by_zero, e[63:32], e[31:0], e[64]);
      else passed++;
      @(negedge clk);
    end
  endtask

  task automatic test_div_by_zero;
    logic [31:0] va[2] = '{32'd1234, 32'hFFFF_FFFB};
    logic        vs[2] = '{1'b0, 1'b1};
    logic [W-1:0] e;
    int cyc;
    for (int i = 0; i < 2; i++) begin
      drive_start(vs[i], va[i], 32'd0, 1);
      cyc = 1;
      wait_done(cyc);
      checks++;
      if (cyc !== 33) $display("FAIL dbz_latency[%0d]: %0d cycles, required 33", i, cyc);
      else passed++;
      e = exp_q.pop_front();
      checks++;
      if ({div_by_zero, quotient, remainder} !== e)
        $display("FAIL dbz_result[%0d]: q=%h r=%h dbz=%b, required q=%h r=%h dbz=%b",
                 i, quotient, remainder, div_by_zero, e[63:32], e[31:0], e[64]);
      else passed++;
      @(negedge clk);
    end
  endtask

  task automatic test_ignored_start;
    logic [W-1:0] e;
    int cyc;
    int extra;
    drive_start(1'b0, 32'd1000, 32'd3, 1);
    repeat (9) @(negedge clk);
    drive_start(1'b0, 32'd7, 32'd7, 0);
    cyc = 11;
    wait_done(cyc);
    checks++;
    if (cyc !== 33) $display("FAIL ignore_latency: %0d cycles, required 33", cyc);
    else passed++;
    e = exp_q.pop_front();
    checks++;
    if ({div_by_zero, quotient, remainder} !== e)
      $display("FAIL ignore_result: q=%h r=%h, required q=%h r=%h", quotient, remainder, e[63:32], e[31:0]);
    else passed++;
    drive_start(1'b0, 32'd9, 32'd2, 0);
    checks++;
    if (busy !== 1'b0 || dbg_state !== IDLE)
      $display("FAIL start_in_done: busy=%b st=%0d, required busy=0 IDLE", busy, dbg_state);
    else passed++;
    extra = 0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1) extra++;
    end
    checks++;
    if (extra !== 0) $display("FAIL ignore_extra_done: %0d extra done pulses, required 0", extra);
    else passed++;
  endtask

  task automatic test_reset_mid_run;
    logic [W-1:0] e;
    int cyc;
    @(negedge clk);
    drive_start(1'b0, 32'd500, 32'd9, 0);
    repeat (14) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy, done, quotient, remainder, div_by_zero} !== 67'd0 || dbg_state !== IDLE)
      $display("FAIL mid_run_reset: busy=%b done=%b q=%h r=%h dbz=%b st=%0d, required all 0 / IDLE",
               busy, done, quotient, remainder, div_by_zero, dbg_state);
    else passed++;
    reset = 1'b0;
    @(negedge clk);
    drive_start(1'b0, 32'd1_000_003, 32'd1013, 1);
    cyc = 1;
    wait_done(cyc);
    checks++;
    if (cyc !== 33) $display("FAIL after_reset_latency: %0d cycles, required 33", cyc);
    else passed++;
    e = exp_q.pop_front();
    checks++;
    if ({div_by_zero, quotient, remainder} !== e)
      $display("FAIL after_reset_result: q=%h r=%h, required q=%h r=%h", quotient, remainder, e[63:32], e[31:0]);
    else passed++;
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    logic [W-1:0] e;
    int cyc;
    drive_start(1'b0, 32'd77777, 32'd123, 1);
    cyc = 1;
    wait_done(cyc);
    e = exp_q.pop_front();
    checks++;
    if ({div_by_zero, quotient, remainder} !== e)
      $display("FAIL b2b_first: q=%h r=%h, required q=%h r=%h", quotient, remainder, e[63:32], e[31:0]);
    else passed++;
    @(negedge clk);
    checks++;
    if (quotient !== e[63:32] || remainder !== e[31:0] || busy !== 1'b0)
      $display("FAIL b2b_hold: q=%h r=%h busy=%b, required q=%h r=%h busy=0",
               quotient, remainder, busy, e[63:32], e[31:0]);
    else passed++;
    drive_start(1'b0, 32'hCAFE_F00D, 32'd65537, 1);
    checks++;
    if (quotient !== 32'd0 || remainder !== 32'd0 || busy !== 1'b1)
      $display("FAIL b2b_clear: q=%h r=%h busy=%b, required 0 0 1", quotient, remainder, busy);
    else passed++;
    cyc = 1;
    wait_done(cyc);
    checks++;
    if (cyc !== 33) $display("FAIL b2b_latency: %0d cycles, required 33", cyc);
    else passed++;
    e = exp_q.pop_front();
    checks++;
    if ({div_by_zero, quotient, remainder} !== e)
      $display("FAIL b2b_second: q=%h r=%h, required q=%h r=%h", quotient, remainder, e[63:32], e[31:0]);
    else passed++;
    @(negedge clk);
  endtask

  task automatic test_random;
    logic [W-1:0] e;
    logic [31:0]  a, b;
    logic         sgn;
    int cyc;
    for (int i = 0; i < 16; i++) begin
      a = $urandom;
      case ($urandom_range(0, 3))
        0: b = 32'($urandom_range(1, 255));
        1: b = $urandom;
        2: b = 32'hFFFF_FFFF - 32'($urandom_range(0, 15));
        default: b = 32'($urandom_range(0, 3));
      endcase
      sgn = 1'($urandom_range(0, 1));
      drive_start(sgn, a, b, 1);
      cyc = 1;
      wait_done(cyc);
      e = exp_q.pop_front();
      checks++;
      if (cyc !== 33 || {div_by_zero, quotient, remainder} !== e)
        $display("FAIL random[%0d]: s=%b %h/%h cyc=%0d q=%h r=%h dbz=%b, required cyc=33 q=%h r=%h dbz=%b",
                 i, sgn, a, b, cyc, quotient, remainder, div_by_zero, e[63:32], e[31:0], e[64]);
      else passed++;
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_divu();
    test_signed();
    test_div_by_zero();
    test_ignored_start();
    test_reset_mid_run();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/divider_32bit.md
# divider_32bit

Multi-cycle 32-bit integer divider for the MIPS datapath, executing div/divu by restoring shift-subtract at one quotient bit per clock. The existing 32-bit add/subtract unit runs in subtract mode as the trial-subtract stage. Results feed the HI/LO registers. A start/done handshake lets the control unit stall while the divider is busy.

## Interface
- WIDTH, 32, operand and result width; only 32 is supported.
- clk  input  1  system clock, rising edge.
- reset  input  1  reset, synchronous and active-high.
- start  input  1  one-cycle request; accepted only in IDLE.
- is_signed  input  1  1 = div (two's complement), 0 = divu; sampled with start.
- dividend  input  32  numerator; sampled with start.
- divisor  input  32  denominator; sampled with start.
- busy  output  1  high from the cycle after acceptance until done falls.
- done  output  1  one-cycle pulse; results valid from this cycle.
- quotient  output  32  result, destined for LO.
- remainder  output  32  result, destined for HI.
- div_by_zero  output  1  divisor was zero; valid with done, held with results.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE to RUN on start: latch operand magnitudes (see Configuration), record the sign flags, clear the remainder register, load the bit counter with 31.
- RUN step:
  - shifted = {rem[30:0], q[31]}; q shifts left by one.
  - Trial-subtract divisor from shifted.
  - Accept if rem[31] was 1 or the subtractor reports no borrow (carry_out=0). Accepting sets rem=difference and q[0]=1; otherwise rem=shifted and q[0]=0.
- RUN to DONE after the step with counter 0 (32 steps).
- DONE applies the sign fix-up, drives done=1, then returns to IDLE.
- Arithmetic: magnitudes are unsigned 32-bit. The borrow-out of the subtract is the only compare. No 33-bit adder.
- Divide by zero: quotient=32'hFFFF_FFFF, remainder=original dividend, div_by_zero=1, with no sign fix-up. The full 32 cycles still run.
- Signed overflow (32'h8000_0000 / -1): quotient=32'h8000_0000, remainder=0, no flag.
- start while busy: ignored, with no queueing.
- start in the same cycle as DONE: ignored, because the FSM is not yet in IDLE.
- reset at any time, including mid-RUN: next state IDLE and all outputs 0. The in-flight operation is discarded.
- quotient, remainder and div_by_zero hold their values until the next accepted start, then go to 0 while busy.

## Timing
- Reset values: busy=0, done=0, quotient=0, remainder=0, div_by_zero=0.
- start accepted at edge 0. busy=1 in cycles 1 through 33. The 32 RUN steps occupy cycles 1–32.
- DONE is cycle 33: done=1 and results valid. Latency is 33 cycles from start to done.
- The earliest next accepted start is at cycle 34, so back-to-back throughput is 1 divide per 34 cycles.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Configuration
- DIVIDER_SIGNED_EN defined:
  - is_signed=1 takes the absolute value of both operands at acceptance.
  - In DONE, the quotient is negated if the operand signs differ.
  - In DONE, the remainder is negated if the dividend was negative.
- DIVIDER_SIGNED_EN undefined:
  - is_signed is ignored and every operation is divu.
  - No negation logic is synthesized.

## Structure
- divider_pkg holds:
  - the state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2);
  - DIV_WIDTH=32;
  - DIV_CNT_W=5;
  - DIV_BY_ZERO_Q=32'hFFFF_FFFF.
- One sub-module: adder_32bit, instantiated with carry_in tied to 1 as the trial subtractor. Its carry_out is the borrow flag.
- Negation for the signed fix-up reuses the same subtract form (0 − x). No behavioural "-" operator.

## Test plan
- divu 100 / 7 -> done at cycle 33, quotient=14, remainder=2, div_by_zero=0.
- div −100 / 7 (DIVIDER_SIGNED_EN) -> quotient=32'hFFFF_FFF2 (−14), remainder=32'hFFFF_FFFE (−2).
- divu 32'hFFFF_FFFF / 1 -> quotient=32'hFFFF_FFFF, remainder=0. divu 5 / 32'hFFFF_FFFF -> quotient=0, remainder=5.
- divu 1234 / 0 -> quotient=32'hFFFF_FFFF, remainder=1234, div_by_zero=1. div 32'h8000_0000 / 32'hFFFF_FFFF -> quotient=32'h8000_0000, remainder=0.
- Second start pulsed at cycle 10 of an operation -> ignored. Exactly one done at cycle 33 with the first operation's results.
- reset asserted at cycle 15 -> busy, done and all results 0 next cycle. A new start at cycle 17 -> correct result at cycle 50.
